mul_result_accum: RTL and testbench

MUL_RESULT_ACCUM -- requirements
Module: mul_result_accum

---
 rtl/mul_result_accum.sv | 96 +++++++++
 tb/tb_mul_result_accum.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_accum.sv
// Accumulates ACC_W-bit saturating sums of signed products, one per ready edge of the upstream multiplier.
// Result 1 cycle after the final edge; held in OUT until acc_ready, starts ignored outside IDLE.
module mul_result_accum #(
   parameter int ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [3:0]              len,
   input  logic signed [15:0]      prod_in,
   input  logic                    rdy_in,
   output logic                    mul_restart,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    acc_valid,
   input  logic                    acc_ready,
   output logic                    busy,
   output logic                    sat
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RESTART = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_OUT     = 2'd3;

   localparam logic [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

   logic [1:0]              state, state_nxt;
   logic [4:0]              remaining;
   logic                    rdy_q;
   logic                    rdy_stale;
   logic                    rise;
   logic signed [ACC_W-1:0] acc;
   logic [ACC_W:0]          sum;
   logic                    ovf_pos, ovf_neg;
   logic [ACC_W:0]          sum_sat;

   // A ready level that survives the RESTART cycle is left over from the
   // previous product; it must drop and rise again before it counts.
   assign rise = (state == S_WAIT) && rdy_in && !rdy_q && !rdy_stale;

   // One guard bit: the top two bits disagree exactly when the sum overflows.
   assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W-15){prod_in[15]}}, prod_in};
   assign ovf_pos = (sum[ACC_W:ACC_W-1] == 2'b01);
   assign ovf_neg = (sum[ACC_W:ACC_W-1] == 2'b10);
   assign sum_sat = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : sum);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_RESTART;
         S_RESTART: state_nxt = S_WAIT;
         S_WAIT:    if (rise) state_nxt = (remaining == 5'd1) ? S_OUT : S_RESTART;
         S_OUT:     if (acc_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         acc       <= '0;
         sat       <= 1'b0;
         remaining <= 5'd0;
         rdy_q     <= 1'b0;
         rdy_stale <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != S_IDLE);

         if (state == S_RESTART) begin
            rdy_q     <= 1'b0;
            rdy_stale <= rdy_in;
         end else begin
            rdy_q <= rdy_in;
            if (!rdy_in) rdy_stale <= 1'b0;
         end

         if (state == S_IDLE && start) begin
            acc       <= '0;
            sat       <= 1'b0;
            remaining <= (len == 4'd0) ? 5'd16 : {1'b0, len};
         end else if (rise) begin
            acc       <= sum_sat[ACC_W-1:0];
            remaining <= remaining - 5'd1;
            if (ovf_pos || ovf_neg) sat <= 1'b1;
         end
      end
   end

   assign mul_restart = (state == S_RESTART);
   assign acc_valid   = (state == S_OUT);
   assign acc_out     = acc;

endmodule

// File: tb/tb_mul_result_accum.sv
// Bench for mul_result_accum (ACC_W=17): table vectors, hand-written corner sequences and
// random runs against a saturating-sum reference model; the multiplier is modelled by tasks.
module tb_mul_result_accum;

   localparam int W = 17;

   logic                clk = 1'b0;
   logic                reset, start, rdy_in, acc_ready;
   logic [3:0]          len;
   logic signed [15:0]  prod_in;
   logic                mul_restart, acc_valid, busy, sat;
   logic signed [W-1:0] acc_out;

   int compared   = 0;
   int mismatched = 0;
   int restarts   = 0;
   logic signed [15:0] prods [16];

   typedef struct {
      logic [3:0]         l;
      int                 n;
      logic signed [15:0] p0, p1, p2, p3;
      longint             acc;
      bit                 s;
      int                 hold;
   } vec_t;

   vec_t tbl [7];

   mul_result_accum #(.ACC_W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .prod_in(prod_in),
      .rdy_in(rdy_in), .mul_restart(mul_restart), .acc_out(acc_out),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .busy(busy), .sat(sat)
   );

   always #5 clk = ~clk;

   // Pre-edge value of the pulse; only this process writes the counter.
   always @(posedge clk) if (mul_restart === 1'b1) restarts++;

   task automatic check(input string name, input longint act, input longint exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint model_sum(input int n, output bit s);
      longint a  = 0;
      longint mx = (longint'(1) <<< (W-1)) - 1;
      longint mn = -(longint'(1) <<< (W-1));
      s = 1'b0;
      for (int i = 0; i < n; i++) begin
         a = a + longint'(prods[i]);
         if (a > mx) begin a = mx; s = 1'b1; end
         else if (a < mn) begin a = mn; s = 1'b1; end
      end
      return a;
   endfunction

   task automatic wait_restart(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (mul_restart === 1'b1) begin ok = 1'b1; return; end
         @(negedge clk);
      end
      check("restart_timeout", 0, 1);
   endtask

   // Multiplier model: ready drops on restart, rises with the product a few cycles later.
   task automatic feed(input int n, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         wait_restart(ok);
         if (!ok) return;
         rdy_in = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         prod_in = prods[i];
         rdy_in  = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic accept(input string name, input longint exp_acc, input int hold, input int base, input int n);
      for (int h = 0; h < hold; h++) begin
         start = (h == 1);
         @(negedge clk);
         start = 1'b0;
         check($sformatf("%s.hold_valid%0d", name, h), acc_valid, 1);
         check($sformatf("%s.hold_acc%0d", name, h), acc_out, exp_acc);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      check({name, ".valid_fall"}, acc_valid, 0);
      check({name, ".busy_idle"}, busy, 0);
      @(negedge clk);
      check({name, ".acc_kept"}, acc_out, exp_acc);
      check({name, ".no_extra_restart"}, restarts - base, n);
   endtask

   task automatic run_check(input string name, input logic [3:0] l, input int n,
                            input longint exp_acc, input bit exp_sat, input int hold);
      int base;
      bit ok;
      base  = restarts;
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
      feed(n, ok);
      if (!ok) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         return;
      end
      check({name, ".valid"}, acc_valid, 1);
      check({name, ".acc"}, acc_out, exp_acc);
      check({name, ".sat"}, sat, exp_sat);
      check({name, ".busy"}, busy, 1);
      check({name, ".restarts"}, restarts - base, n);
      accept(name, exp_acc, hold, base, n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit     ok, s;
      int     base, n;
      longint e;
      logic [3:0] l;

      tbl[0] = '{4'd1, 1, 16'sd9,     16'sd0,     16'sd0,     16'sd0,     64'sd9,      1'b0, 0};
      tbl[1] = '{4'd3, 3, 16'sd100,   -16'sd50,   16'sd7,     16'sd0,     64'sd57,     1'b0, 1};
      tbl[2] = '{4'd3, 3, 16'h7FFF,   16'h7FFF,   16'h7FFF,   16'sd0,     64'sd65535,  1'b1, 0};
      tbl[3] = '{4'd3, 3, 16'h8000,   16'h8000,   16'h8000,   16'sd0,     -64'sd65536, 1'b1, 2};
      tbl[4] = '{4'd2, 2, 16'h7FFF,   16'h8000,   16'sd0,     16'sd0,     -64'sd1,     1'b0, 0};
      tbl[5] = '{4'd4, 4, 16'h7FFF,   16'h7FFF,   16'h7FFF,   16'h8000,   64'sd32767,  1'b1, 5};
      tbl[6] = '{4'd2, 2, -16'sd1,    -16'sd1,    16'sd0,     16'sd0,     -64'sd2,     1'b0, 1};

      reset = 1'b1; start = 1'b0; len = 4'd0; prod_in = '0; rdy_in = 1'b0; acc_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.acc_out", acc_out, 0);
      check("reset.acc_valid", acc_valid, 0);
      check("reset.mul_restart", mul_restart, 0);
      check("reset.busy", busy, 0);
      check("reset.sat", sat, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         prods[0] = tbl[i].p0; prods[1] = tbl[i].p1; prods[2] = tbl[i].p2; prods[3] = tbl[i].p3;
         run_check($sformatf("vec%0d", i), tbl[i].l, tbl[i].n, tbl[i].acc, tbl[i].s, tbl[i].hold);
      end

      // Ready held high across a restart is one product, not two.
      base  = restarts;
      start = 1'b1; len = 4'd2;
      @(negedge clk);
      start = 1'b0;
      wait_restart(ok);
      if (ok) begin
         rdy_in = 1'b0;
         repeat (2) @(negedge clk);
         prod_in = 16'sd123; rdy_in = 1'b1;
         repeat (11) @(negedge clk);
         check("hold.no_valid", acc_valid, 0);
         check("hold.busy", busy, 1);
         check("hold.restarts", restarts - base, 2);
         rdy_in = 1'b0;
         @(negedge clk);
         prod_in = -16'sd4; rdy_in = 1'b1;
         @(negedge clk);
         check("hold.valid", acc_valid, 1);
         check("hold.acc", acc_out, 119);
         accept("hold", 119, 0, base, 2);
      end

      // Reset in the middle of a run.
      prods[0] = 16'sd1000; prods[1] = 16'sd2000;
      start = 1'b1; len = 4'd4;
      @(negedge clk);
      start = 1'b0;
      feed(2, ok);
      reset = 1'b1;
      #1;
      check("midreset.acc_out", acc_out, 0);
      check("midreset.acc_valid", acc_valid, 0);
      check("midreset.mul_restart", mul_restart, 0);
      check("midreset.busy", busy, 0);
      check("midreset.sat", sat, 0);
      @(negedge clk);
      reset = 1'b0; rdy_in = 1'b0;
      @(negedge clk);
      check("midreset.idle", busy, 0);
      for (int i = 0; i < 16; i++) prods[i] = 16'($urandom);
      e = model_sum(16, s);
      run_check("len16", 4'd0, 16, e, s, 1);

      for (int r = 0; r < 20; r++) begin
         l = 4'($urandom_range(0, 15));
         n = (l == 4'd0) ? 16 : int'(l);
         for (int i = 0; i < 16; i++)
            prods[i] = (r % 2 == 1) ? (($urandom_range(0, 1) == 1) ? 16'sh7F00 + 16'($urandom_range(0, 255))
                                                                  : 16'sh8000 + 16'($urandom_range(0, 255)))
                                    : 16'($urandom);
         e = model_sum(n, s);
         run_check($sformatf("rand%0d", r), l, n, e, s, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
